// File: rtl/lfsr_pattern_gen_if.sv
// lfsr_pattern_gen_if
// Bundles the BIST pattern generator's control and pattern signals.
//   start, stall   : run control from the BIST controller
//   operand_a/b    : operand pair for the multiplier under test
//   pattern_valid  : operands hold a new pattern this cycle
//   pattern_index  : low bits of the count of patterns issued in this run
//   misr_reset     : reset request to the signature compactor
//   done           : run finished, signature may be read
// Modports: master = pattern generator side, slave = controller/consumer side.
interface lfsr_pattern_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             stall;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             pattern_valid;
  logic [4:0]       pattern_index;
  logic             misr_reset;
  logic             done;

  modport master (
    input  start, stall,
    output operand_a, operand_b, pattern_valid, pattern_index, misr_reset, done
  );

  modport slave (
    output start, stall,
    input  operand_a, operand_b, pattern_valid, pattern_index, misr_reset, done
  );
endinterface

// File: rtl/lfsr_pattern_gen.sv
// lfsr_pattern_gen
// BIST stimulus source: a 16-bit Galois LFSR (x^16 + x^5 + x^3 + x^2 + 1)
// produces PAIRS operand pairs for the multiplier under test, holding the
// signature compactor in reset while idle and flagging completion.
// Ports:
//   clk            : single clock, rising edge
//   reset_to_lfsr  : asynchronous active-high reset
//   bus (master)   : start/stall in; operands, pattern_valid, pattern_index,
//                    misr_reset, done out
module lfsr_pattern_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PAIRS = 32,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic                clk,
  input logic                reset_to_lfsr,
  lfsr_pattern_gen_if.master bus
);

  localparam int unsigned LW = 2 * WIDTH;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [LW-1:0] LOAD_VALUE = (SEED == 16'h0000) ? LW'(1) : LW'(SEED);
  localparam logic [LW-1:0] TAPS       = LW'(16'h002D);
  localparam logic [15:0]   LAST_COUNT = 16'(PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [LW-1:0] lfsr;
  logic [LW-1:0] lfsr_stepped;
  logic [15:0]   count;
  logic          load;
  logic          advance;
  logic          valid_d;
  logic          misr_reset_d;
  logic          done_d;

  // Galois step: shift left, fold the outgoing MSB back into the tap bits.
  assign lfsr_stepped = {lfsr[LW-2:0], 1'b0} ^ (lfsr[LW-1] ? TAPS : '0);

  always_ff @(posedge clk or posedge reset_to_lfsr) begin
    if (reset_to_lfsr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend only on state, plus stall gating pattern_valid in RUN.
  // A restart from DONE deliberately leaves misr_reset low so a back-to-back
  // run keeps compacting on top of the previous signature.
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    advance      = 1'b0;
    valid_d      = 1'b0;
    misr_reset_d = 1'b0;
    done_d       = 1'b0;
    unique case (state)
      IDLE: begin
        misr_reset_d = 1'b1;
        if (bus.start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        valid_d = ~bus.stall;
        if (!bus.stall) begin
          advance = 1'b1;
          if (count == LAST_COUNT) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (bus.start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The final pattern still steps the LFSR, but count stays at PAIRS-1 so
  // pattern_index keeps showing the last issued index while DONE.
  always_ff @(posedge clk or posedge reset_to_lfsr) begin
    if (reset_to_lfsr) begin
      lfsr  <= LOAD_VALUE;
      count <= 16'd0;
    end else if (load) begin
      lfsr  <= LOAD_VALUE;
      count <= 16'd0;
    end else if (advance) begin
      lfsr <= lfsr_stepped;
      if (count != LAST_COUNT) begin
        count <= count + 16'd1;
      end
    end
  end

  assign bus.operand_a     = lfsr[LW-1:WIDTH];
  assign bus.operand_b     = lfsr[WIDTH-1:0];
  assign bus.pattern_index = count[4:0];
  assign bus.pattern_valid = valid_d;
  assign bus.misr_reset    = misr_reset_d;
  assign bus.done          = done_d;

endmodule

// File: doc/lfsr_pattern_gen.md
# lfsr_pattern_gen

BIST stimulus source for the radix-4 multiplier: a 16-bit LFSR produces a fixed pseudo-random sequence of operand pairs that drives the multiplier inputs. The multiplier's product goes to the signature compactor. The LFSR uses the same characteristic polynomial as that compactor, x^16 + x^5 + x^3 + x^2 + 1. The block sequences one BIST run: it holds the compactor in reset, issues PAIRS operand pairs with an optional stall, then reports completion.

## Interface
Parameters:
- WIDTH, 8, operand width; the LFSR is 2*WIDTH = 16 bits.
- PAIRS, 32, number of operand pairs issued per run (2..2^16).
- SEED, 16'hACE1, LFSR load value. If SEED is 0, 16'h0001 is loaded instead.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_to_lfsr  in  1  asynchronous, active-high reset.
- start  in  1  begins a run; sampled only in IDLE or DONE.
- stall  in  1  holds the current pattern for one cycle (bubble).
- operand_a  out  WIDTH  lfsr[15:8], driven straight from the register.
- operand_b  out  WIDTH  lfsr[7:0], driven straight from the register.
- pattern_valid  out  1  the operands are a new pattern for this cycle.
- pattern_index  out  5  count of patterns issued so far in this run.
- misr_reset  out  1  reset request to the signature compactor.
- done  out  1  run complete; the signature may now be read.

## Operation
- Registers:
  - state: IDLE, RUN or DONE.
  - lfsr[15:0].
  - count[15:0]; pattern_index = count[4:0].
- LFSR step (Galois form), with s the current value:
  - next = {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000).
  - This makes next[0]=s15, next[2]=s1^s15, next[3]=s2^s15, next[5]=s4^s15; every other bit is a plain shift.
- IDLE:
  - misr_reset=1, pattern_valid=0, done=0; lfsr and count hold.
  - start=1 → RUN; lfsr←SEED, count←0.
- RUN:
  - misr_reset=0, done=0, pattern_valid=~stall.
  - stall=0 and count<PAIRS-1: lfsr←step, count←count+1.
  - stall=0 and count==PAIRS-1: → DONE; lfsr steps once more, count holds.
  - stall=1: lfsr, count and state all hold.
  - start is ignored in RUN.
- DONE:
  - done=1, pattern_valid=0, misr_reset=0; lfsr and count hold.
  - start=1 → RUN; lfsr←SEED, count←0. The compactor is not reset on this path, so a back-to-back rerun keeps compacting on top of the previous signature.
- Outputs pattern_valid, misr_reset and done are decoded from state and stall only (Moore, plus stall gating of pattern_valid).

## Timing
- Reset values:
  - state=IDLE, lfsr=SEED, count=0.
  - operand_a=8'hAC, operand_b=8'hE1.
  - pattern_valid=0, pattern_index=0, misr_reset=1, done=0.
- Asserting reset_to_lfsr at any time, including mid-run, forces all of the above immediately, without waiting for a clock edge. After deassertion the block waits in IDLE for start.
- Start latency: with start high at edge E0, RUN begins after E0. pattern 0 (the SEED halves) is valid during the cycle after E0, and misr_reset falls in that same cycle.
- Throughput: with no stall, pattern k is valid in cycle k after E0, for k = 0..PAIRS-1.
- Completion: done rises in the cycle after pattern PAIRS-1, giving exactly PAIRS valid cycles per run.
- Each stall cycle delays every later pattern, and done, by one cycle. A stall in the last RUN cycle delays the DONE transition.
- The operands are registered and stable for the whole cycle. The multiplier is combinational, so the product of pattern k is present in the same cycle.

## Test plan
- Reset value: assert reset_to_lfsr asynchronously between edges → outputs go at once to AC/E1, misr_reset=1, pattern_valid=0, done=0.
- Sequence: pulse start with no stall → operand pairs (AC,E1), (59,EF), (B3,DE), (67,91) on the first four valid cycles with pattern_index 0,1,2,3. Then exactly 32 valid cycles, done=1 on cycle 32, pattern_valid=0 afterwards.
- Stall: raise stall in the cycle that shows (59,EF) → pattern_valid=0 for that cycle, operands and index hold. (B3,DE) appears one cycle later and done rises on cycle 33.
- Mid-run reset: assert reset_to_lfsr at pattern 10 → immediately IDLE state with seed outputs. A following start restarts at (AC,E1), index 0.
- Restart and ignore:
  - start held high throughout RUN → no restart; the sequence is unchanged.
  - start in DONE → reload SEED; the sequence repeats identically; misr_reset stays 0.
- Full check against a reference model: 32 pairs fed to a behavioural multiplier and compactor model → the final signature matches the model's value for SEED=16'hACE1, compactor started from 16'h8000.
